// File: rtl/step_seq_ctrl_pkg.sv
// Shared definitions for the setpoint sequencer: default widths and FSM encoding.
package step_seq_ctrl_pkg;

    localparam int DW    = 21;  // reference / target width
    localparam int TW    = 16;  // dwell counter width
    localparam int SEG_N = 8;   // table entries
    localparam int AW    = 3;   // table address width, clog2(SEG_N)

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RAMP  = 3'd2,
        ST_DWELL = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/step_seq_ctrl_if.sv
// Configuration, control and status bundle of the setpoint sequencer.
interface step_seq_ctrl_if
    import step_seq_ctrl_pkg::*;
#(
    parameter int P_DW = DW,
    parameter int P_TW = TW,
    parameter int P_AW = AW
);
    // table programming
    logic              cfg_we;
    logic [P_AW-1:0]   cfg_addr;
    logic [P_DW-1:0]   cfg_target;
    logic [P_TW-1:0]   cfg_dwell;
    // run control
    logic [P_DW-1:0]   slew;
    logic [P_AW:0]     num_seg;
    logic              loop_en;
    logic              start;
    logic              abort;
    // status
    logic [P_DW-1:0]   out;
    logic [P_AW-1:0]   seg_idx;
    logic              busy;
    logic              at_target;
    logic              done;

    modport master (
        output cfg_we, cfg_addr, cfg_target, cfg_dwell,
        output slew, num_seg, loop_en, start, abort,
        input  out, seg_idx, busy, at_target, done
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_target, cfg_dwell,
        input  slew, num_seg, loop_en, start, abort,
        output out, seg_idx, busy, at_target, done
    );

endinterface

// File: rtl/step_slew_lim.sv
// Rate limiter: computes the next reference value one slew step toward the
// target. Purely combinational; the caller owns the output register.
module step_slew_lim #(
    parameter int DW = 21
) (
    input  logic [DW-1:0] out_i,       // current registered reference
    input  logic [DW-1:0] tgt_i,       // target for this segment
    input  logic [DW-1:0] slew_i,      // max change per clock, 0 = jump
    output logic [DW-1:0] next_out_o,  // value to register this cycle
    output logic          reached_o    // next_out_o equals tgt_i
);

    logic          up_s;
    logic [DW:0]   diff_s;
    logic          reached_s;

    // Distance at DW+1 bits so neither direction can wrap; a step never passes the target.
    always_comb begin
        up_s       = 1'b0;
        diff_s     = {(DW+1){1'b0}};
        reached_s  = 1'b0;
        next_out_o = out_i;
        up_s = (tgt_i >= out_i);
        if (up_s) begin
            diff_s = {1'b0, tgt_i} - {1'b0, out_i};
        end else begin
            diff_s = {1'b0, out_i} - {1'b0, tgt_i};
        end
        reached_s = (slew_i == {DW{1'b0}}) || (diff_s <= {1'b0, slew_i});
        if (reached_s) begin
            next_out_o = tgt_i;
        end else if (up_s) begin
            next_out_o = out_i + slew_i;
        end else begin
            next_out_o = out_i - slew_i;
        end
    end

    assign reached_o = reached_s;

endmodule

// File: rtl/step_seq_ctrl.sv
// Setpoint sequencer: walks a small table of {target, dwell} segments,
// slewing the reference toward each target and then holding it.
module step_seq_ctrl
    import step_seq_ctrl_pkg::*;
#(
    parameter int DW    = step_seq_ctrl_pkg::DW,
    parameter int TW    = step_seq_ctrl_pkg::TW,
    parameter int SEG_N = step_seq_ctrl_pkg::SEG_N,
    parameter int AW    = step_seq_ctrl_pkg::AW
) (
    input  logic             clk,
    input  logic             rst,
    step_seq_ctrl_if.slave   bus
);

    localparam logic [AW-1:0] SEG_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [TW-1:0] DCNT_ONE = {{(TW-1){1'b0}}, 1'b1};

    // segment table (not reset: contents are undefined until written)
    logic [DW-1:0] tbl_target_q [SEG_N];
    logic [TW-1:0] tbl_dwell_q  [SEG_N];

    state_t        state_q;
    logic [DW-1:0] out_q;
    logic [DW-1:0] tgt_q;
    logic [TW-1:0] dcnt_q;
    logic [AW-1:0] seg_idx_q;
    logic          busy_q;
    logic          at_target_q;
    logic          done_q;

    logic [DW-1:0] out_d;
    logic          reached_s;
    logic          cfg_ok_s;
    logic [AW:0]   seg_next_s;
    logic          more_seg_s;

    step_slew_lim #(.DW(DW)) u_slew (
        .out_i      (out_q),
        .tgt_i      (tgt_q),
        .slew_i     (bus.slew),
        .next_out_o (out_d),
        .reached_o  (reached_s)
    );

    // Table write qualification and "another segment follows" decision.
    always_comb begin
        cfg_ok_s   = 1'b0;
        seg_next_s = {(AW+1){1'b0}};
        more_seg_s = 1'b0;
        if (bus.cfg_we && !busy_q && (32'(bus.cfg_addr) < 32'(SEG_N))) begin
            cfg_ok_s = 1'b1;
        end else begin
            cfg_ok_s = 1'b0;
        end
        seg_next_s = {1'b0, seg_idx_q} + {{AW{1'b0}}, 1'b1};
        more_seg_s = (seg_next_s < bus.num_seg);
    end

    // Table storage: writes land only while the sequencer is not running.
    always_ff @(posedge clk) begin
        if (cfg_ok_s) begin
            tbl_target_q[bus.cfg_addr] <= bus.cfg_target;
            tbl_dwell_q[bus.cfg_addr]  <= bus.cfg_dwell;
        end
    end

    // Sequencer FSM with registered reference and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            out_q       <= {DW{1'b0}};
            tgt_q       <= {DW{1'b0}};
            dcnt_q      <= {TW{1'b0}};
            seg_idx_q   <= {AW{1'b0}};
            busy_q      <= 1'b0;
            at_target_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.abort) begin
                // freeze the reference and segment index where they are
                state_q     <= ST_IDLE;
                busy_q      <= 1'b0;
                at_target_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE, ST_DONE: begin
                        if (bus.start) begin
                            if (bus.num_seg != {(AW+1){1'b0}}) begin
                                state_q   <= ST_LOAD;
                                seg_idx_q <= {AW{1'b0}};
                                busy_q    <= 1'b1;
                            end else begin
                                done_q <= 1'b1;
                            end
                        end
                    end
                    ST_LOAD: begin
                        tgt_q   <= tbl_target_q[seg_idx_q];
                        dcnt_q  <= tbl_dwell_q[seg_idx_q];
                        state_q <= ST_RAMP;
                    end
                    ST_RAMP: begin
                        out_q <= out_d;
                        if (reached_s) begin
                            state_q     <= ST_DWELL;
                            at_target_q <= 1'b1;
                        end
                    end
                    ST_DWELL: begin
                        // dwell of 0 or 1 both give a single DWELL cycle
                        if (dcnt_q > DCNT_ONE) begin
                            dcnt_q <= dcnt_q - DCNT_ONE;
                        end else begin
                            at_target_q <= 1'b0;
                            if (more_seg_s) begin
                                seg_idx_q <= seg_idx_q + SEG_ONE;
                                state_q   <= ST_LOAD;
                            end else if (bus.loop_en) begin
                                seg_idx_q <= {AW{1'b0}};
                                state_q   <= ST_LOAD;
                            end else begin
                                state_q <= ST_DONE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_q     <= ST_IDLE;
                        busy_q      <= 1'b0;
                        at_target_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.out       = out_q;
    assign bus.seg_idx   = seg_idx_q;
    assign bus.busy      = busy_q;
    assign bus.at_target = at_target_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_step_seq_ctrl.sv
// Self-checking bench for step_seq_ctrl: table-driven single-segment runs,
// directed corner sequences and random profiles against a trace model.
module tb_step_seq_ctrl;
    import step_seq_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    step_seq_ctrl_if bus ();

    step_seq_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [20:0] out;
        logic [2:0]  seg;
        logic        busy;
        logic        at;
        logic        done;
    } obs_t;

    typedef struct {
        int tgt;
        int dwell;
        int slew;
        int exp_busy;  // busy cycles seen from start to the done pulse
        int exp_at;    // at_target cycles in that window
    } vec_t;

    obs_t exp_q[$];
    int   m_tgt [8];
    int   m_dwell [8];
    int   m_out;
    int   vectors = 0;
    int   miscompares = 0;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // one reference step toward t, limited to s (s == 0 means jump)
    function automatic int step_toward(int o, int t, int s);
        int d;
        d = (t > o) ? t - o : o - t;
        if (s == 0 || d <= s) return t;
        return (t > o) ? o + s : o - s;
    endfunction

    function automatic void push_obs(int o, int s, bit b, bit a, bit d);
        obs_t e;
        e.out  = 21'(o);
        e.seg  = 3'(s);
        e.busy = b;
        e.at   = a;
        e.done = d;
        exp_q.push_back(e);
    endfunction

    // Expected per-cycle outputs after the edge that samples start.
    // Each segment: one load cycle, one ramp-entry cycle with the old value,
    // the intermediate slew values, then max(dwell,1) cycles at the target.
    task automatic build_trace(input int nseg, input bit lp, input int slew, input int max_obs);
        int o;
        int s;
        int t;
        int d;
        o = m_out;
        s = 0;
        exp_q.delete();
        while (exp_q.size() < max_obs) begin
            push_obs(o, s, 1'b1, 1'b0, 1'b0);
            push_obs(o, s, 1'b1, 1'b0, 1'b0);
            t = m_tgt[s];
            do begin
                o = step_toward(o, t, slew);
                if (o != t) push_obs(o, s, 1'b1, 1'b0, 1'b0);
            end while (o != t);
            d = (m_dwell[s] == 0) ? 1 : m_dwell[s];
            repeat (d) push_obs(t, s, 1'b1, 1'b1, 1'b0);
            if (s < nseg - 1) begin
                s++;
            end else if (lp) begin
                s = 0;
            end else begin
                push_obs(o, s, 1'b0, 1'b0, 1'b1);
                push_obs(o, s, 1'b0, 1'b0, 1'b0);
                break;
            end
        end
    endtask

    task automatic check_obs(input int i);
        check($sformatf("obs%0d.out", i),  64'(bus.out),       64'(exp_q[i].out));
        check($sformatf("obs%0d.seg", i),  64'(bus.seg_idx),   64'(exp_q[i].seg));
        check($sformatf("obs%0d.busy", i), 64'(bus.busy),      64'(exp_q[i].busy));
        check($sformatf("obs%0d.at", i),   64'(bus.at_target), 64'(exp_q[i].at));
        check($sformatf("obs%0d.done", i), 64'(bus.done),      64'(exp_q[i].done));
    endtask

    // Pulse start, then compare n cycles; optionally attempt a table write at cycle wr_at.
    task automatic run_trace(input int n, input int wr_at);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (i > 0) tick();
            bus.cfg_we = 1'b0;
            check_obs(i);
            if (i == wr_at) begin
                bus.cfg_we     = 1'b1;
                bus.cfg_addr   = 3'd0;
                bus.cfg_target = 21'd7;
                bus.cfg_dwell  = 16'd9;
            end
        end
        bus.cfg_we = 1'b0;
    endtask

    task automatic cfg_write(input int a, input int t, input int d);
        bus.cfg_we     = 1'b1;
        bus.cfg_addr   = 3'(a);
        bus.cfg_target = 21'(t);
        bus.cfg_dwell  = 16'(d);
        tick();
        bus.cfg_we = 1'b0;
        m_tgt[a]   = t;
        m_dwell[a] = d;
    endtask

    initial begin
        vec_t vt [6];
        int   nb;
        int   na;
        int   got;
        int   idx;
        int   ns;
        int   sl;

        vt[0] = '{1000,    5, 0,       7, 5};
        vt[1] = '{50,      2, 300,     7, 2};
        vt[2] = '{50,      0, 7,       3, 1};
        vt[3] = '{2097151, 1, 1048576, 4, 1};
        vt[4] = '{0,       3, 1048576, 6, 3};
        vt[5] = '{1000,    1, 300,     6, 1};

        bus.cfg_we = 1'b0; bus.cfg_addr = 3'd0; bus.cfg_target = 21'd0; bus.cfg_dwell = 16'd0;
        bus.slew = 21'd0; bus.num_seg = 4'd0; bus.loop_en = 1'b0;
        bus.start = 1'b0; bus.abort = 1'b0;
        m_out = 0;

        // reset
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        check("rst.out",  64'(bus.out),       64'd0);
        check("rst.busy", 64'(bus.busy),      64'd0);
        check("rst.done", 64'(bus.done),      64'd0);
        check("rst.seg",  64'(bus.seg_idx),   64'd0);
        check("rst.at",   64'(bus.at_target), 64'd0);
        tick();

        // table-driven single-segment runs (out carries over row to row)
        for (int v = 0; v < 6; v++) begin
            cfg_write(0, vt[v].tgt, vt[v].dwell);
            bus.slew = 21'(vt[v].slew); bus.num_seg = 4'd1; bus.loop_en = 1'b0;
            bus.start = 1'b1;
            tick();
            bus.start = 1'b0;
            nb = 0; na = 0; got = 0;
            for (int c = 0; c < 300; c++) begin
                if (bus.done) begin
                    got = 1;
                    break;
                end
                nb += int'(bus.busy);
                na += int'(bus.at_target);
                tick();
            end
            check($sformatf("vec%0d.done_seen", v), 64'(got), 64'd1);
            check($sformatf("vec%0d.busy_cycles", v), 64'(nb), 64'(vt[v].exp_busy));
            check($sformatf("vec%0d.at_cycles", v), 64'(na), 64'(vt[v].exp_at));
            check($sformatf("vec%0d.out", v), 64'(bus.out), 64'(vt[v].tgt));
            m_out = vt[v].tgt;
            tick();
            check($sformatf("vec%0d.done_once", v), 64'(bus.done), 64'd0);
        end

        // downward ramp 1000 -> 50 at slew 300: 700, 400, 100, 50
        cfg_write(0, 50, 2);
        bus.slew = 21'd300;
        build_trace(1, 1'b0, 300, 100000);
        run_trace(exp_q.size(), -1);
        m_out = exp_q[exp_q.size()-1].out;

        // num_seg = 0: single done pulse, reference untouched
        bus.num_seg = 4'd0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("nseg0.done", 64'(bus.done), 64'd1);
        check("nseg0.busy", 64'(bus.busy), 64'd0);
        check("nseg0.out",  64'(bus.out),  64'(m_out));
        tick();
        check("nseg0.done_once", 64'(bus.done), 64'd0);

        // start and abort together: abort wins
        bus.num_seg = 4'd1;
        bus.start = 1'b1; bus.abort = 1'b1;
        tick();
        bus.start = 1'b0; bus.abort = 1'b0;
        check("sa.busy", 64'(bus.busy), 64'd0);
        check("sa.done", 64'(bus.done), 64'd0);
        tick();
        check("sa.busy2", 64'(bus.busy), 64'd0);
        check("sa.out",   64'(bus.out),  64'(m_out));

        // three looping segments, abort in the middle of segment 1's dwell
        cfg_write(0, 500, 2);
        cfg_write(1, 2000, 3);
        cfg_write(2, 0, 1);
        bus.slew = 21'd0; bus.num_seg = 4'd3; bus.loop_en = 1'b1;
        build_trace(3, 1'b1, 0, 60);
        idx = -1;
        for (int i = 12; i < exp_q.size(); i++) begin
            if (idx < 0 && exp_q[i].seg == 3'd1 && exp_q[i].at) idx = i;
        end
        if (idx < 0) idx = 18;
        run_trace(idx + 2, -1);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("abort.busy", 64'(bus.busy),    64'd0);
        check("abort.out",  64'(bus.out),     64'd2000);
        check("abort.seg",  64'(bus.seg_idx), 64'd1);
        check("abort.done", 64'(bus.done),    64'd0);
        tick();
        check("abort.hold", 64'(bus.out),     64'd2000);
        check("abort.idle", 64'(bus.busy),    64'd0);
        m_out = 2000;
        bus.loop_en = 1'b0;

        // table write attempted while busy must not land; replay shows old target
        cfg_write(0, 1234, 3);
        bus.num_seg = 4'd1;
        build_trace(1, 1'b0, 0, 100000);
        run_trace(exp_q.size(), 1);
        m_out = exp_q[exp_q.size()-1].out;
        build_trace(1, 1'b0, 0, 100000);
        run_trace(exp_q.size(), -1);
        m_out = exp_q[exp_q.size()-1].out;

        // random multi-segment profiles
        for (int r = 0; r < 8; r++) begin
            for (int a = 0; a < 8; a++) begin
                cfg_write(a, int'($urandom_range(2097151, 0)), int'($urandom_range(4, 0)));
            end
            sl = ($urandom_range(3, 0) == 0) ? 0 : int'($urandom_range(2097151, 16384));
            ns = int'($urandom_range(8, 1));
            bus.slew = 21'(sl);
            bus.num_seg = 4'(ns);
            build_trace(ns, 1'b0, sl, 100000);
            run_trace(exp_q.size(), -1);
            m_out = exp_q[exp_q.size()-1].out;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
